// File: rtl/imem_loader.sv
// Byte-stream program loader for the instruction memory write port.
// Ports: clk, rst, start, load_len, byte_* handshake, we/waddr/wdata, busy, cpu_hold, done, words_written.
module imem_loader #(
  parameter int n = 32,
  parameter int r = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [r:0]   load_len,
  input  logic         byte_valid,
  input  logic [7:0]   byte_data,
  output logic         byte_ready,
  output logic         we,
  output logic [r-1:0] waddr,
  output logic [n-1:0] wdata,
  output logic         busy,
  output logic         cpu_hold,
  output logic         done,
  output logic [r:0]   words_written
);

  localparam int BPW = n / 8;
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [CW-1:0] LAST  = CW'(BPW - 1);
  localparam logic [r:0]    DEPTH = {1'b1, {r{1'b0}}};

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RECV  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state;
  logic [r:0]    len;
  logic [CW-1:0] cnt;
  logic [n-1:0]  shreg;

  logic          accept;
  logic [n+7:0]  shifted;
  logic [n-1:0]  next_word;
  logic [r:0]    clamp;
  logic [r:0]    ww_inc;

  always_comb begin
    shifted   = {shreg, byte_data};
    next_word = shifted[n-1:0];
    clamp     = (load_len > DEPTH) ? DEPTH : load_len;
    ww_inc    = words_written + 1'b1;
    // rst gates the handshake and the write strobe in the same cycle
    // so an aborted load never consumes a byte or writes memory.
    byte_ready = (state == S_RECV) && !rst;
    we         = (state == S_WRITE) && !rst;
    accept     = byte_valid && byte_ready;
    busy       = (state == S_RECV) || (state == S_WRITE);
    cpu_hold   = busy;
    done       = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      len           <= '0;
      cnt           <= '0;
      shreg         <= '0;
      waddr         <= '0;
      wdata         <= '0;
      words_written <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            len           <= clamp;
            words_written <= '0;
            cnt           <= '0;
            shreg         <= '0;
            state         <= (clamp == '0) ? S_DONE : S_RECV;
          end
        end
        S_RECV: begin
          if (accept) begin
            shreg <= next_word;
            if (cnt == LAST) begin
              // Present the finished word during the WRITE cycle.
              cnt   <= '0;
              wdata <= next_word;
              waddr <= words_written[r-1:0];
              state <= S_WRITE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_WRITE: begin
          words_written <= ww_inc;
          state         <= (ww_inc == len) ? S_DONE : S_RECV;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: word-level model plus directed cases.
// Randomized byte data, gaps and lengths; summary line at the end.
module tb_imem_loader;

  logic        clk = 0;
  logic        rst = 1;
  logic        start = 0;
  logic [6:0]  load_len = 0;
  logic        byte_valid = 0;
  logic [7:0]  byte_data = 0;
  logic        byte_ready;
  logic        we;
  logic [5:0]  waddr;
  logic [31:0] wdata;
  logic        busy;
  logic        cpu_hold;
  logic        done;
  logic [6:0]  words_written;

  imem_loader #(.n(32), .r(6)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .load_len(load_len),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .byte_ready(byte_ready),
    .we(we),
    .waddr(waddr),
    .wdata(wdata),
    .busy(busy),
    .cpu_hold(cpu_hold),
    .done(done),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Word-level model: loading flag, pending write, bytes of the
  // current word in a queue, words completed so far.
  bit          armed = 0;
  bit          m_loading = 0;
  bit          m_we = 0;
  bit          m_done = 0;
  int          m_len = 0;
  int          m_wc = 0;
  logic [5:0]  m_addr = 0;
  logic [31:0] m_data = 0;
  logic [7:0]  q[$];
  logic [31:0] log_data[$];
  logic [5:0]  log_addr[$];

  always @(negedge clk) begin
    if (armed) begin
      chk("byte_ready", byte_ready, m_loading && !m_we && !rst);
      chk("we", we, m_we && !rst);
      chk("busy", busy, m_loading);
      chk("cpu_hold", cpu_hold, m_loading);
      chk("done", done, m_done);
      chk("words_written", words_written, m_wc);
      chk("waddr", waddr, m_addr);
      chk("wdata", wdata, m_data);
      if (we === 1'b1) begin
        log_addr.push_back(waddr);
        log_data.push_back(wdata);
      end
    end
    if (rst) begin
      armed = 1;
      m_loading = 0;
      m_we = 0;
      m_done = 0;
      m_len = 0;
      m_wc = 0;
      m_addr = 0;
      m_data = 0;
      q.delete();
    end else if (m_we) begin
      m_wc++;
      m_we = 0;
      if (m_wc == m_len) begin
        m_loading = 0;
        m_done = 1;
      end
    end else if (!m_loading && start) begin
      m_len = (load_len > 64) ? 64 : int'(load_len);
      m_wc = 0;
      m_done = (m_len == 0);
      m_loading = (m_len != 0);
      q.delete();
    end else if (m_loading && byte_valid) begin
      q.push_back(byte_data);
      if (q.size() == 4) begin
        m_data = {q[0], q[1], q[2], q[3]};
        m_addr = m_wc[5:0];
        m_we = 1;
        q.delete();
      end
    end
  end

  task automatic cyc(input int k = 1);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input int len);
    start = 1;
    load_len = 7'(len);
    cyc();
    start = 0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    bit acc;
    int t;
    byte_valid = 0;
    if (gap > 0) cyc(gap);
    byte_valid = 1;
    byte_data = b;
    acc = 0;
    t = 0;
    while (!acc && t < 200) begin
      @(negedge clk);
      acc = byte_ready;
      @(posedge clk);
      #1;
      t++;
    end
    if (!acc) chk("send_timeout", 0, 1);
    byte_valid = 0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (done !== 1'b1 && t < 2000) begin
      cyc();
      t++;
    end
    if (done !== 1'b1) chk("done_timeout", 0, 1);
  endtask

  logic [7:0] prog1[8] = '{8'h8C, 8'h01, 8'h00, 8'h04,
                           8'h20, 8'h02, 8'h00, 8'h05};

  initial begin
    rst = 1;
    cyc(2);
    rst = 0;
    cyc();
    chk("rst_we", we, 0);
    chk("rst_ready", byte_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_ww", words_written, 0);

    // two words back-to-back
    log_data.delete();
    log_addr.delete();
    do_start(2);
    foreach (prog1[i]) send(prog1[i], 0);
    wait_done();
    chk("t1_nwrites", log_data.size(), 2);
    if (log_data.size() >= 2) begin
      chk("t1_d0", log_data[0], 32'h8C010004);
      chk("t1_a0", log_addr[0], 0);
      chk("t1_d1", log_data[1], 32'h20020005);
      chk("t1_a1", log_addr[1], 1);
    end
    chk("t1_ww", words_written, 2);

    // zero length
    log_data.delete();
    log_addr.delete();
    do_start(0);
    chk("t2_done", done, 1);
    chk("t2_ww", words_written, 0);
    cyc(3);
    chk("t2_nwrites", log_data.size(), 0);

    // full depth, gapped valid, index pattern
    log_data.delete();
    log_addr.delete();
    do_start(64);
    for (int w = 0; w < 64; w++)
      for (int b = 0; b < 4; b++) send(8'(w), 1);
    wait_done();
    chk("t3_nwrites", log_data.size(), 64);
    if (log_data.size() == 64) begin
      chk("t3_d0", log_data[0], 32'h00000000);
      chk("t3_d63", log_data[63], 32'h3F3F3F3F);
      chk("t3_a63", log_addr[63], 63);
    end
    byte_valid = 1;
    byte_data = 8'hAA;
    cyc(4);
    chk("t3_ready_done", byte_ready, 0);
    byte_valid = 0;

    // start while busy, then abort with a partial word
    do_start(3);
    for (int i = 0; i < 6; i++) send(8'($urandom), 0);
    start = 1;
    load_len = 7'd1;
    cyc();
    start = 0;
    for (int i = 0; i < 5; i++) send(8'($urandom), 0);
    log_data.delete();
    log_addr.delete();
    rst = 1;
    cyc();
    rst = 0;
    chk("t4_nwrites", log_data.size(), 0);
    chk("t4_ww", words_written, 0);
    chk("t4_busy", busy, 0);
    do_start(1);
    for (int i = 0; i < 4; i++) send(8'($urandom), 0);
    wait_done();
    chk("t4_n2", log_data.size(), 1);
    if (log_data.size() == 1) chk("t4_a0", log_addr[0], 0);

    // reset landing on the WRITE cycle
    do_start(2);
    for (int i = 0; i < 4; i++) send(8'($urandom), 0);
    log_data.delete();
    log_addr.delete();
    rst = 1;
    cyc();
    rst = 0;
    cyc();
    chk("t5_nwrites", log_data.size(), 0);

    // clamp of an oversize length
    do_start(127);
    for (int i = 0; i < 256; i++)
      send(8'($urandom), $urandom_range(0, 2));
    wait_done();
    chk("t6_ww", words_written, 64);

    // random loads, with stray start pulses
    for (int k = 0; k < 8; k++) begin
      int len;
      len = $urandom_range(0, 9);
      do_start(len);
      for (int i = 0; i < 4 * len; i++) begin
        if ($urandom_range(0, 7) == 0) begin
          start = 1;
          load_len = 7'($urandom);
          cyc();
          start = 0;
        end
        send(8'($urandom), $urandom_range(0, 3));
      end
      wait_done();
      chk("rnd_ww", words_written, len);
      cyc($urandom_range(0, 3));
    end

    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
